// File: rtl/uart_test_pkg.sv
// Shared types for the UART loopback exerciser: controller states and pattern modes.
package uart_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int MODE_INC  = 0;
  localparam int MODE_LFSR = 1;

endpackage

// File: rtl/pattern_gen.sv
// Test word source: incrementing count or Galois LFSR, one step per advance pulse.
// load restarts from the seed; the word output is a register.
module pattern_gen
  import uart_test_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                MODE      = MODE_INC,
  parameter logic [DATA_W-1:0] SEED      = '0,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  // An all-zero LFSR state would lock up, so a zero seed starts the LFSR at 1.
  localparam logic [DATA_W-1:0] SEED_EFF =
    ((MODE == MODE_LFSR) && (SEED == '0)) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] word_nxt;

  always_comb begin
    word_nxt = word + DATA_W'(1);
    if (MODE == MODE_LFSR) begin
      word_nxt = (word >> 1) ^ (word[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load) begin
      word <= SEED_EFF;
    end else if (advance) begin
      word <= word_nxt;
    end
  end

endmodule

// File: rtl/uart_loopback_checker.sv
// Loopback exerciser: streams a pattern through the UART TX handshake and checks each RX echo.
// Mismatches, echo timeouts and unsolicited words are counted; verdict and heartbeat drive the LEDs.
module uart_loopback_checker
  import uart_test_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                NUM_BYTES     = 16,
  parameter int                MODE          = MODE_INC,
  parameter logic [DATA_W-1:0] SEED          = '0,
  parameter logic [DATA_W-1:0] LFSR_TAPS     = 8'hB8,
  parameter int                TIMEOUT_CYC   = 100000,
  parameter int                HEARTBEAT_DIV = 25000000,
  parameter int                ERR_W         = 16
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              start,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [5:0]        led
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HB_W  = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_DIV - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   to_cnt;
  logic [HB_W-1:0]   hb_cnt;
  logic              hb;
  logic              sticky_mis;
  logic              sticky_to;
  logic              to_hit;
  logic              last_word;

  logic              load;
  logic              accept;
  logic              echo;
  logic              mismatch;
  logic              timeout;
  logic              spurious;
  logic              step;
  logic [ERR_W-1:0]  err_base;
  logic [ERR_W-1:0]  err_nxt;

  assign to_hit    = (to_cnt == TO_LAST);
  assign last_word = (idx == LAST_IDX);

  pattern_gen #(
    .DATA_W   (DATA_W),
    .MODE     (MODE),
    .SEED     (SEED),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_pattern (
    .clk    (clk_in),
    .rst_n  (reset_n),
    .load   (load),
    .advance(step),
    .word   (tx_data)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SEND;
      ST_SEND:          if (tx_ready) state_nxt = ST_WAIT_RX;
      ST_WAIT_RX:       if (rx_valid || to_hit) state_nxt = last_word ? ST_DONE : ST_SEND;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // An echo on the timeout cycle wins; tx_data still holds the outstanding word for comparison.
  always_comb begin
    load     = start && ((state == ST_IDLE) || (state == ST_DONE));
    accept   = (state == ST_SEND) && tx_ready;
    echo     = (state == ST_WAIT_RX) && rx_valid;
    mismatch = echo && (rx_data != tx_data);
    timeout  = (state == ST_WAIT_RX) && !rx_valid && to_hit;
    spurious = rx_valid && (state != ST_WAIT_RX);
    step     = echo || timeout;
    err_base = load ? '0 : err_cnt;
    err_nxt  = err_base;
    if ((mismatch || timeout || spurious) && (err_base != '1)) begin
      err_nxt = err_base + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      sticky_mis <= 1'b0;
      sticky_to  <= 1'b0;
      idx        <= '0;
      to_cnt     <= '0;
    end else begin
      tx_valid   <= (state_nxt == ST_SEND);
      busy       <= (state_nxt == ST_SEND) || (state_nxt == ST_WAIT_RX);
      done       <= (state_nxt == ST_DONE);
      pass       <= (state_nxt == ST_DONE) && (err_nxt == '0);
      err_cnt    <= err_nxt;
      sticky_mis <= (load ? 1'b0 : sticky_mis) | mismatch | spurious;
      sticky_to  <= (load ? 1'b0 : sticky_to) | timeout;
      if (load) begin
        idx <= '0;
      end else if (step && !last_word) begin
        idx <= idx + IDX_W'(1);
      end
      if (load || accept) begin
        to_cnt <= '0;
      end else if ((state == ST_WAIT_RX) && !rx_valid && !to_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  assign led = {sticky_to, sticky_mis, pass, done, busy, hb};

endmodule
